// File: rtl/datapath_pkg.sv
// Shared types and constants for the datapath receive-side blocks.
package datapath_pkg;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned WORD_W      = 64;
    localparam int unsigned FCNT_W      = 26;
    localparam int unsigned PH_W        = 3;
    localparam int unsigned ANT_W       = 2;
    localparam int unsigned ERR_CNT_W   = 16;
    localparam int unsigned ERR_SUM_W   = ERR_CNT_W + 1;
    localparam int unsigned FRAME_CNT_W = 32;

    localparam logic [FCNT_W-1:0] FRAM_MAX_NR  = 26'd4915199;
    localparam logic [FCNT_W-1:0] FRAM_MAX_LTE = 26'd2457599;

    localparam int unsigned XANT_PERIOD_NR  = 4;
    localparam int unsigned XANT_PERIOD_LTE = 8;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } fram_state_e;

    // Antenna-group length in cycles for the selected radio mode.
    function automatic int unsigned xant_period(input bit is_lte);
        return is_lte ? XANT_PERIOD_LTE : XANT_PERIOD_NR;
    endfunction

endpackage

// File: rtl/datapath_xant_demux_if.sv
// Interleaved 32-bit antenna stream from the delay stage into the demux.
interface datapath_xant_demux_if;
    import datapath_pkg::*;

    logic              i_fram_hd;
    logic              i_xant_hd;
    logic [DATA_W-1:0] i_data;

    modport master (output i_fram_hd, output i_xant_hd, output i_data);
    modport slave  (input  i_fram_hd, input  i_xant_hd, input  i_data);

endinterface

// File: rtl/datapath_fram_check.sv
// Frame-period tracker: owns the frame counter, the HUNT/SYNC/LOCKED
// machine and the frame-error pulse.
// Optional DATAPATH_XANT_DEMUX_STATS_EN adds a good-frame counter for debug.
module datapath_fram_check
    import datapath_pkg::*;
#(
    parameter logic [FCNT_W-1:0] FRAM_MAX = FRAM_MAX_NR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_fram_hd,
    output fram_state_e o_state,
    output logic        o_locked,
    output logic        o_err_fram
);

    fram_state_e       state_q, state_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              err_fram_q, err_fram_d;
    logic              locked_q;
    logic              fcnt_full;

    assign fcnt_full = (fcnt_q == FRAM_MAX);

    // Cycles since the last frame header, saturating.
    always_comb begin
        fcnt_d = fcnt_q;
        if (i_fram_hd) begin
            fcnt_d = '0;
        end else if (fcnt_q != '1) begin
            fcnt_d = fcnt_q + FCNT_W'(1);
        end
    end

    // Next-state and frame-error decision.
    always_comb begin
        state_d    = state_q;
        err_fram_d = 1'b0;
        case (state_q)
            HUNT: begin
                if (i_fram_hd) begin
                    state_d = SYNC;
                end
            end
            SYNC: begin
                if (i_fram_hd) begin
                    if (fcnt_full) begin
                        state_d = LOCKED;
                    end else begin
                        err_fram_d = 1'b1;
                    end
                end else if (fcnt_full) begin
                    state_d    = HUNT;
                    err_fram_d = 1'b1;
                end
            end
            LOCKED: begin
                if (i_fram_hd) begin
                    if (!fcnt_full) begin
                        state_d    = SYNC;
                        err_fram_d = 1'b1;
                    end
                end else if (fcnt_full) begin
                    state_d    = HUNT;
                    err_fram_d = 1'b1;
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase
    end

    // State, counter and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= HUNT;
            fcnt_q     <= '0;
            err_fram_q <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            fcnt_q     <= fcnt_d;
            err_fram_q <= err_fram_d;
            locked_q   <= (state_d == LOCKED);
        end
    end

`ifdef DATAPATH_XANT_DEMUX_STATS_EN
    logic [FRAME_CNT_W-1:0] frame_cnt_q;

    // Good headers seen while locked, for the debug probe.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else if ((state_q == LOCKED) && i_fram_hd && fcnt_full) begin
            frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
        end
    end
`endif

    assign o_state    = state_q;
    assign o_locked   = locked_q;
    assign o_err_fram = err_fram_q;

endmodule

// File: rtl/datapath_xant_demux.sv
// Receive-side antenna demux: re-packs 32-bit halves into 64-bit per-antenna
// words, checks antenna-group alignment and reports frame lock.
// Optional DATAPATH_XANT_DEMUX_STATS_EN enables the saturating error count.
module datapath_xant_demux
    import datapath_pkg::*;
#(
    parameter string             MODE     = "NR",
    parameter logic [FCNT_W-1:0] FRAM_MAX = FRAM_MAX_NR
) (
    input  logic                 clk,
    input  logic                 rst,
    datapath_xant_demux_if.slave rx,
    output logic                 o_fram_hd,
    output logic                 o_valid,
    output logic [ANT_W-1:0]     o_ant_idx,
    output logic [WORD_W-1:0]    o_data,
    output logic                 o_locked,
    output logic                 o_err_xant,
    output logic                 o_err_fram,
    output logic [ERR_CNT_W-1:0] o_err_cnt
);

    localparam bit              IS_LTE  = (MODE == "LTE");
    localparam int unsigned     PERIOD  = xant_period(IS_LTE);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(PERIOD - 1);
    localparam logic [PH_W-1:0] PH_ANT0 = PH_W'(1);

    fram_state_e       state;
    logic              hunting;

    logic [PH_W-1:0]   ph_q, ph_d;
    logic [DATA_W-1:0] lo_q;
    logic              fhd_pend_q, fhd_pend_d;
    logic              valid_q, valid_d;
    logic              fram_hd_q, fram_hd_d;
    logic [ANT_W-1:0]  ant_idx_q, ant_idx_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic              err_xant_q, err_xant_d;

    datapath_fram_check #(
        .FRAM_MAX (FRAM_MAX)
    ) u_fram_check (
        .clk        (clk),
        .rst        (rst),
        .i_fram_hd  (rx.i_fram_hd),
        .o_state    (state),
        .o_locked   (o_locked),
        .o_err_fram (o_err_fram)
    );

    assign hunting = (state == HUNT);

    // Group phase: a frame header restarts it, otherwise wraps at PERIOD.
    always_comb begin
        ph_d = ph_q + PH_W'(1);
        if (rx.i_fram_hd || (ph_q == PH_LAST)) begin
            ph_d = '0;
        end
    end

    // Pairing of halves into words, frame-start marker and alignment check.
    always_comb begin
        valid_d    = 1'b0;
        fram_hd_d  = 1'b0;
        ant_idx_d  = ant_idx_q;
        data_d     = data_q;
        fhd_pend_d = fhd_pend_q;
        err_xant_d = !hunting && (rx.i_xant_hd != (ph_q == PH_LAST));

        if (ph_q[0]) begin
            data_d    = {rx.i_data, lo_q};
            ant_idx_d = ph_q[2:1];
            valid_d   = !hunting;
            fram_hd_d = !hunting && fhd_pend_q && (ph_q == PH_ANT0);
        end

        // Marker waits for the first antenna-0 word after a header.
        if (rx.i_fram_hd) begin
            fhd_pend_d = 1'b1;
        end else if (ph_q == PH_ANT0) begin
            fhd_pend_d = 1'b0;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ph_q       <= '0;
            lo_q       <= '0;
            fhd_pend_q <= 1'b0;
            valid_q    <= 1'b0;
            fram_hd_q  <= 1'b0;
            ant_idx_q  <= '0;
            data_q     <= '0;
            err_xant_q <= 1'b0;
        end else begin
            ph_q       <= ph_d;
            fhd_pend_q <= fhd_pend_d;
            valid_q    <= valid_d;
            fram_hd_q  <= fram_hd_d;
            ant_idx_q  <= ant_idx_d;
            data_q     <= data_d;
            err_xant_q <= err_xant_d;
            if (!ph_q[0]) begin
                lo_q <= rx.i_data;
            end
        end
    end

`ifdef DATAPATH_XANT_DEMUX_STATS_EN
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [ERR_SUM_W-1:0] err_sum;

    // Adds this cycle's error pulses, saturating at all-ones.
    always_comb begin
        err_sum   = ERR_SUM_W'(err_cnt_q) + ERR_SUM_W'(err_xant_q) + ERR_SUM_W'(o_err_fram);
        err_cnt_d = err_sum[ERR_CNT_W] ? '1 : err_sum[ERR_CNT_W-1:0];
    end

    // Error count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign o_err_cnt = err_cnt_q;
`else
    assign o_err_cnt = '0;
`endif

    assign o_fram_hd  = fram_hd_q;
    assign o_valid    = valid_q;
    assign o_ant_idx  = ant_idx_q;
    assign o_data     = data_q;
    assign o_err_xant = err_xant_q;

endmodule

// File: tb/tb_datapath_xant_demux.sv
// Bench for datapath_xant_demux: an NR and an LTE instance (frame length 64)
// fed the same header/data stream, each with its own antenna-header pattern,
// compared every cycle against a cycle-position reference model.
module tb_datapath_xant_demux;

    localparam logic [25:0] FM     = 26'd63;
    localparam int          FLEN   = 64;
    localparam int          SAT    = 67108863;
    localparam int          S_HUNT = 0;
    localparam int          S_SYNC = 1;
    localparam int          S_LOCK = 2;
`ifdef DATAPATH_XANT_DEMUX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    datapath_xant_demux_if if_nr ();
    datapath_xant_demux_if if_lte ();

    logic        fhd [2];
    logic        vld [2];
    logic [1:0]  idx [2];
    logic [63:0] dat [2];
    logic        lck [2];
    logic        exa [2];
    logic        efr [2];
    logic [15:0] ecn [2];

    datapath_xant_demux #(.MODE("NR"), .FRAM_MAX(FM)) u_nr (
        .clk(clk), .rst(rst), .rx(if_nr),
        .o_fram_hd(fhd[0]), .o_valid(vld[0]), .o_ant_idx(idx[0]), .o_data(dat[0]),
        .o_locked(lck[0]), .o_err_xant(exa[0]), .o_err_fram(efr[0]), .o_err_cnt(ecn[0])
    );

    datapath_xant_demux #(.MODE("LTE"), .FRAM_MAX(FM)) u_lte (
        .clk(clk), .rst(rst), .rx(if_lte),
        .o_fram_hd(fhd[1]), .o_valid(vld[1]), .o_ant_idx(idx[1]), .o_data(dat[1]),
        .o_locked(lck[1]), .o_err_xant(exa[1]), .o_err_fram(efr[1]), .o_err_cnt(ecn[1])
    );

    int ncmp = 0;
    int nerr = 0;

    // Reference model: position within the current frame, lock state, held low half.
    int          m_st  [2];
    int          m_pos [2];
    bit          m_pend[2];
    logic [31:0] m_lo  [2];
    bit          e_v   [2];
    bit          e_fh  [2];
    bit          e_ex  [2];
    bit          e_ef  [2];
    bit          e_lk  [2];
    logic [1:0]  e_idx [2];
    logic [63:0] e_dat [2];
    int          e_cnt [2];
    bit          e_rst;

    int          gp   = 0;
    logic [31:0] ramp = 32'd0;
    bit          use_ramp = 1'b1;

    function automatic int per(input int m);
        return (m == 0) ? 4 : 8;
    endfunction

    function automatic void model_step(input int m, input bit hd, input bit xh,
                                       input logic [31:0] d, input bit r);
        int p;
        int ph;
        int fc;
        bit full;
        if (r) begin
            m_st[m] = S_HUNT; m_pos[m] = 0; m_pend[m] = 1'b0; m_lo[m] = '0;
            e_v[m] = 1'b0; e_fh[m] = 1'b0; e_ex[m] = 1'b0; e_ef[m] = 1'b0;
            e_lk[m] = 1'b0; e_idx[m] = '0; e_dat[m] = '0; e_cnt[m] = 0;
            return;
        end
        p  = per(m);
        ph = m_pos[m] % p;
        e_cnt[m] = e_cnt[m] + int'(e_ex[m]) + int'(e_ef[m]);
        if (e_cnt[m] > 65535) e_cnt[m] = 65535;
        e_v[m]  = 1'b0;
        e_fh[m] = 1'b0;
        if ((ph % 2) == 1) begin
            e_dat[m] = {d, m_lo[m]};
            e_idx[m] = 2'(ph / 2);
            e_v[m]   = (m_st[m] != S_HUNT);
            e_fh[m]  = e_v[m] && (ph == 1) && m_pend[m];
        end
        e_ex[m] = (m_st[m] != S_HUNT) && (xh != (ph == p - 1));
        fc   = (m_pos[m] > SAT) ? SAT : m_pos[m];
        full = (fc == int'(FM));
        e_ef[m] = 1'b0;
        if (m_st[m] == S_HUNT) begin
            if (hd) m_st[m] = S_SYNC;
        end else if (hd) begin
            if (full) m_st[m] = S_LOCK;
            else begin m_st[m] = S_SYNC; e_ef[m] = 1'b1; end
        end else if (full) begin
            m_st[m] = S_HUNT; e_ef[m] = 1'b1;
        end
        e_lk[m] = (m_st[m] == S_LOCK);
        if ((ph % 2) == 0) m_lo[m] = d;
        if (hd) begin
            m_pos[m] = 0; m_pend[m] = 1'b1;
        end else begin
            m_pos[m] = m_pos[m] + 1;
            if (ph == 1) m_pend[m] = 1'b0;
        end
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input bit hd, input bit x0, input bit x1, input logic [31:0] d, input bit r);
        @(negedge clk);
        rst = r;
        if_nr.i_fram_hd  = hd;  if_lte.i_fram_hd = hd;
        if_nr.i_xant_hd  = x0;  if_lte.i_xant_hd = x1;
        if_nr.i_data     = d;   if_lte.i_data    = d;
        @(posedge clk);
        model_step(0, hd, x0, d, r);
        model_step(1, hd, x1, d, r);
        e_rst = r;
        #1;
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("valid[%0d] t=%0t", m, $time), 64'(vld[m]), 64'(e_v[m]));
            chk($sformatf("fram_hd[%0d] t=%0t", m, $time), 64'(fhd[m]), 64'(e_fh[m]));
            chk($sformatf("locked[%0d] t=%0t", m, $time), 64'(lck[m]), 64'(e_lk[m]));
            chk($sformatf("err_xant[%0d] t=%0t", m, $time), 64'(exa[m]), 64'(e_ex[m]));
            chk($sformatf("err_fram[%0d] t=%0t", m, $time), 64'(efr[m]), 64'(e_ef[m]));
            chk($sformatf("err_cnt[%0d] t=%0t", m, $time), 64'(ecn[m]),
                STATS ? 64'(e_cnt[m]) : 64'd0);
            if (e_v[m] || e_rst) begin
                chk($sformatf("ant_idx[%0d] t=%0t", m, $time), 64'(idx[m]), 64'(e_idx[m]));
                chk($sformatf("data[%0d] t=%0t", m, $time), dat[m], e_dat[m]);
            end
        end
    endtask

    // One source cycle: headers every FLEN cycles, antenna headers on each
    // group's last cycle, with optional forced/blocked header and flipped xant.
    task automatic gcyc(input bit hd_force, input bit hd_block, input bit [1:0] xflip, input bit r);
        bit          hd;
        bit          x0;
        bit          x1;
        logic [31:0] d;
        hd = ((gp == FLEN - 1) && !hd_block) || hd_force;
        x0 = ((gp % 4) == 3) ^ xflip[0];
        x1 = ((gp % 8) == 7) ^ xflip[1];
        d  = use_ramp ? ramp : $urandom();
        cyc(hd, x0, x1, d, r);
        if (hd) begin
            gp = 0; ramp = '0;
        end else begin
            gp = (gp + 1) % FLEN; ramp = ramp + 32'd1;
        end
    endtask

    task automatic norm(input int n);
        for (int i = 0; i < n; i++) gcyc(1'b0, 1'b0, 2'b00, 1'b0);
    endtask

    initial begin
        bit [1:0] xf;
        // Reset state.
        gcyc(1'b0, 1'b0, 2'b00, 1'b1);
        gcyc(1'b0, 1'b0, 2'b00, 1'b1);

        // Ramp data: SYNC after the first header, LOCKED after the second.
        norm(3 * FLEN);

        // Random data while locked.
        use_ramp = 1'b0;
        norm(2 * FLEN);

        // Early header at frame position 40, then resynchronise.
        while (gp != 40) norm(1);
        gcyc(1'b1, 1'b0, 2'b00, 1'b0);
        norm(2 * FLEN);

        // Early header together with a spurious antenna header.
        while (gp != 42) norm(1);
        gcyc(1'b1, 1'b0, 2'b11, 1'b0);
        norm(2 * FLEN);

        // One antenna header moved to phase 1 of its group.
        while (gp != 16) norm(1);
        for (int k = 0; k < 8; k++)
            gcyc(1'b0, 1'b0, {(gp == 17) || (gp == 23), (gp == 17) || (gp == 19)}, 1'b0);
        norm(FLEN);

        // Header withheld: drop to HUNT, then re-acquire.
        while (gp != FLEN - 1) norm(1);
        gcyc(1'b0, 1'b1, 2'b00, 1'b0);
        norm(3 * FLEN);

        // Sparse random header and antenna-header faults.
        for (int i = 0; i < 2 * FLEN; i++) begin
            xf = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            gcyc($urandom_range(0, 79) == 0, 1'b0, xf, 1'b0);
        end
        norm(2 * FLEN);

        // One-cycle reset mid-frame, then recovery.
        while (gp != 25) norm(1);
        gcyc(1'b0, 1'b0, 2'b00, 1'b1);
        norm(3 * FLEN);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
